adder_share_arbiter: RTL

- Shares one combinational kogge_stone_adder among NUM_REQ requesters.
- Round-robin arbitration with valid/ready handshakes on each requester port and on the single result port.
- Result is registered with the winning requester's ID, sum and carry_out.
- Sits between several independent datapath clients and one adder instance, so the design needs only one wide adder.

---
 rtl/adder_share_arbiter_pkg.sv | 15 +
 rtl/kogge_stone_adder.sv | 36 +++
 rtl/round_robin_arbiter.sv | 33 +++
 rtl/adder_share_arbiter.sv | 109 ++++++++++
 4 files changed

// File: rtl/adder_share_arbiter_pkg.sv
// Shared definitions for the adder-sharing arbiter: occupancy state encoding
// and the ID-width derivation used by shared-resource arbiters.
package adder_share_arbiter_pkg;

  typedef enum logic {
    OCC_EMPTY = 1'b0,
    OCC_FULL  = 1'b1
  } occ_e;

  // Index width for n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return ($clog2(n) > 0) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/kogge_stone_adder.sv
// Combinational parallel-prefix (Kogge-Stone) adder with no carry-in.
module kogge_stone_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  // Prefix tree: each level merges (g,p) pairs that are a doubling distance apart.
  function automatic logic [WIDTH:0] ks_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] gn;
    logic [WIDTH-1:0] pn;
    logic [WIDTH-1:0] p0;
    g  = x & y;
    p  = x ^ y;
    p0 = p;
    for (int d = 1; d < WIDTH; d = d * 2) begin
      gn = g;
      pn = p;
      for (int i = d; i < WIDTH; i++) begin
        gn[i] = g[i] | (p[i] & g[i-d]);
        pn[i] = p[i] & p[i-d];
      end
      g = gn;
      p = pn;
    end
    return {g[WIDTH-1], p0 ^ (g << 1)};
  endfunction

  assign {carry_out, sum} = ks_add(a, b);

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin grant: scans from ptr upward with wrap; first valid request wins.
module round_robin_arbiter import adder_share_arbiter_pkg::*; #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               found
);

  logic [NUM_REQ-1:0] raw;

  // Priority scan starting at ptr; grant is gated by enable, idx/found are not.
  always_comb begin
    raw   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        idx   = ID_W'((int'(ptr) + k) % NUM_REQ);
        raw[(int'(ptr) + k) % NUM_REQ] = 1'b1;
      end else begin
        found = found;
      end
    end
    grant = raw & {NUM_REQ{enable}};
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one Kogge-Stone adder among NUM_REQ requesters with round-robin
// arbitration and a single-entry registered result stage.
module adder_share_arbiter import adder_share_arbiter_pkg::*; #(
  parameter  int WIDTH   = 32,
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [ID_W-1:0]          res_id,
  output logic [WIDTH-1:0]         res_sum,
  output logic                     res_carry
);

  occ_e             occ;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  win_idx;
  logic [ID_W-1:0]  next_ptr;
  logic             win_found;
  logic             can_accept;
  logic             xfer;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_carry;

  assign res_valid = (occ == OCC_FULL);
  // res_ready reaches req_ready combinationally so a drain and a new accept can share a cycle.
  assign can_accept = !res_valid || res_ready;

  round_robin_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (req_valid),
    .ptr    (ptr),
    .enable (can_accept && !rst),
    .grant  (req_ready),
    .idx    (win_idx),
    .found  (win_found)
  );

  assign xfer     = win_found && can_accept && !rst;
  assign next_ptr = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);

  // Only the winner's operands reach the adder, keeping other requesters' data out of res_*.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == ID_W'(i)) begin
        op_a = req_a[i*WIDTH +: WIDTH];
        op_b = req_b[i*WIDTH +: WIDTH];
      end else begin
        op_a = op_a;
      end
    end
  end

  kogge_stone_adder #(.WIDTH(WIDTH)) u_add (
    .a         (op_a),
    .b         (op_b),
    .sum       (add_sum),
    .carry_out (add_carry)
  );

  // Result register, occupancy state and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ       <= OCC_EMPTY;
      ptr       <= '0;
      res_id    <= '0;
      res_sum   <= '0;
      res_carry <= 1'b0;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (xfer) begin
            occ <= OCC_FULL;
          end else begin
            occ <= OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (xfer) begin
            occ <= OCC_FULL;
          end else if (res_ready) begin
            occ <= OCC_EMPTY;
          end else begin
            occ <= OCC_FULL;
          end
        end
        default: occ <= OCC_EMPTY;
      endcase
      if (xfer) begin
        ptr       <= next_ptr;
        res_id    <= win_idx;
        res_sum   <= add_sum;
        res_carry <= add_carry;
      end else begin
        ptr <= ptr;
      end
    end
  end

endmodule
